// File: rtl/two_phase_latch_clkgen_pkg.sv
// Shared constants for the CNT latch clocking: state encodings and default
// phase timing, also used by the latch-stage testbenches.
package cnt_clk_pkg;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_PH1  = 3'd2;
  localparam logic [2:0] ST_GAP1 = 3'd3;
  localparam logic [2:0] ST_PH2  = 3'd4;
  localparam logic [2:0] ST_GAP2 = 3'd5;

  localparam int DEF_PHI_CYCLES  = 2;
  localparam int DEF_GAP_CYCLES  = 1;
  localparam int DEF_INIT_CYCLES = 4;
  localparam int DEF_CNT_WIDTH   = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    return m;
  endfunction

endpackage

// File: rtl/two_phase_latch_clkgen_phase_timer.sv
// Reusable phase down-counter: loaded with (N-1) on state entry, holds at zero;
// the owner advances its state when zero is seen.
module phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: load wins, otherwise decrement until zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != {W{1'b0}}) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero  = (count_q == {W{1'b0}});
  assign count = count_q;

endmodule

// File: rtl/two_phase_latch_clkgen.sv
// Non-overlapping two-phase latch enable generator with latch reset,
// free-run / single-step control and a completed-cycle counter.
module two_phase_latch_clkgen
  import cnt_clk_pkg::*;
#(
  parameter int PHI_CYCLES  = DEF_PHI_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  output logic                 phi1,
  output logic                 phi2,
  output logic                 latch_rst,
  output logic                 cycle_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int TW = $clog2(max3(PHI_CYCLES, GAP_CYCLES, INIT_CYCLES) + 1);
  localparam logic [TW-1:0] PHI_LD  = TW'(PHI_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] INIT_LD = TW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [2:0]           state_q, state_d;
  logic                 init_load_q, init_load_d;
  logic                 phi1_q, phi1_d;
  logic                 phi2_q, phi2_d;
  logic                 latch_rst_q, latch_rst_d;
  logic                 cycle_done_q, cycle_done_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 tmr_zero;
  logic [TW-1:0]        tmr_count;

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero),
    .count    (tmr_count)
  );

  // next state, timer loads, completion pulse and registered output values
  always_comb begin
    state_d      = state_q;
    init_load_d  = init_load_q;
    tmr_load     = 1'b0;
    tmr_val      = {TW{1'b0}};
    cycle_done_d = 1'b0;
    count_d      = count_q;
    case (state_q)
      // reset leaves the timer at zero, so the INIT length is armed on the
      // first edge after rst is released
      ST_INIT: begin
        if (!init_load_q) begin
          tmr_load    = 1'b1;
          tmr_val     = INIT_LD;
          init_load_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (run || step) begin
          state_d  = ST_PH1;
          tmr_load = 1'b1;
          tmr_val  = PHI_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PH1: begin
        if (tmr_zero) begin
          state_d  = ST_GAP1;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end else begin
          state_d = ST_PH1;
        end
      end
      ST_GAP1: begin
        if (tmr_zero) begin
          state_d  = ST_PH2;
          tmr_load = 1'b1;
          tmr_val  = PHI_LD;
        end else begin
          state_d = ST_GAP1;
        end
      end
      ST_PH2: begin
        if (tmr_zero) begin
          state_d  = ST_GAP2;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
          if (GAP_CYCLES == 1) begin
            cycle_done_d = 1'b1;
            count_d      = count_q + CNT_ONE;
          end else begin
            cycle_done_d = 1'b0;
          end
        end else begin
          state_d = ST_PH2;
        end
      end
      ST_GAP2: begin
        if (tmr_zero) begin
          if (run) begin
            state_d  = ST_PH1;
            tmr_load = 1'b1;
            tmr_val  = PHI_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmr_count == T_ONE) begin
          cycle_done_d = 1'b1;
          count_d      = count_q + CNT_ONE;
        end else begin
          state_d = ST_GAP2;
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_load_d = 1'b0;
      end
    endcase

    phi1_d      = (state_d == ST_PH1) || (state_d == ST_INIT);
    phi2_d      = (state_d == ST_PH2) || (state_d == ST_INIT);
    latch_rst_d = (state_d == ST_INIT);
    busy_d      = (state_d != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_load_q  <= 1'b0;
      phi1_q       <= 1'b1;
      phi2_q       <= 1'b1;
      latch_rst_q  <= 1'b1;
      cycle_done_q <= 1'b0;
      busy_q       <= 1'b1;
      count_q      <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      init_load_q  <= init_load_d;
      phi1_q       <= phi1_d;
      phi2_q       <= phi2_d;
      latch_rst_q  <= latch_rst_d;
      cycle_done_q <= cycle_done_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
    end
  end

  assign phi1        = phi1_q;
  assign phi2        = phi2_q;
  assign latch_rst   = latch_rst_q;
  assign cycle_done  = cycle_done_q;
  assign busy        = busy_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_two_phase_latch_clkgen.sv
// Directed scoreboard bench for two_phase_latch_clkgen: default instance plus
// a CNT_WIDTH=4, PHI=1, GAP=3 instance for period and wrap behaviour.
module tb_two_phase_latch_clkgen;

  typedef struct packed {
    logic        p1;
    logic        p2;
    logic        lr;
    logic        dn;
    logic        bz;
    logic [15:0] cnt;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        run_a, step_a, run_b, step_b;
  logic        phi1_a, phi2_a, lr_a, done_a, busy_a;
  logic [15:0] cnt_a;
  logic        phi1_b, phi2_b, lr_b, done_b, busy_b;
  logic [3:0]  cnt_b;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  two_phase_latch_clkgen dut_a (
    .clk(clk), .rst(rst), .run(run_a), .step(step_a),
    .phi1(phi1_a), .phi2(phi2_a), .latch_rst(lr_a),
    .cycle_done(done_a), .busy(busy_a), .cycle_count(cnt_a)
  );

  two_phase_latch_clkgen #(
    .PHI_CYCLES(1), .GAP_CYCLES(3), .INIT_CYCLES(4), .CNT_WIDTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .step(step_b),
    .phi1(phi1_b), .phi2(phi2_b), .latch_rst(lr_b),
    .cycle_done(done_b), .busy(busy_b), .cycle_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // both enables high exactly when latch reset is high (i.e. only in INIT)
  always @(negedge clk) begin
    checks++;
    assert (lr_a === (phi1_a & phi2_a)) else begin
      errors++;
      $error("FAIL overlap_a observed=%b%b%b expected lr==phi1&phi2", phi1_a, phi2_a, lr_a);
    end
    checks++;
    assert (lr_b === (phi1_b & phi2_b)) else begin
      errors++;
      $error("FAIL overlap_b observed=%b%b%b expected lr==phi1&phi2", phi1_b, phi2_b, lr_b);
    end
  end

  task automatic push_const(input logic p1, input logic p2, input logic lr,
                            input logic dn, input logic bz, input int cnt, input int reps);
    obs_t e;
    e.p1 = p1; e.p2 = p2; e.lr = lr; e.dn = dn; e.bz = bz; e.cnt = cnt[15:0];
    for (int i = 0; i < reps; i++) exp_q.push_back(e);
  endtask

  // one full phi1/gap/phi2/gap cycle; only the first n entries are queued
  task automatic push_cycle(input int phi, input int gap, input int cnt,
                            input int mask, input int n);
    obs_t e;
    int   len;
    len = 2 * (phi + gap);
    for (int i = 0; i < len; i++) begin
      e.p1  = (i < phi);
      e.p2  = (i >= phi + gap) && (i < 2 * phi + gap);
      e.lr  = 1'b0;
      e.bz  = 1'b1;
      e.dn  = (i == len - 1);
      e.cnt = e.dn ? 16'((cnt + 1) & mask) : 16'(cnt);
      if (i < n) exp_q.push_back(e);
    end
  endtask

  task automatic check_now(input int sel, input string tag);
    obs_t o, e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (sel == 0) begin
        o.p1 = phi1_a; o.p2 = phi2_a; o.lr = lr_a; o.dn = done_a; o.bz = busy_a; o.cnt = cnt_a;
      end else begin
        o.p1 = phi1_b; o.p2 = phi2_b; o.lr = lr_b; o.dn = done_b; o.bz = busy_b;
        o.cnt = {12'd0, cnt_b};
      end
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic tick(input int sel, input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_now(sel, tag);
    end
  endtask

  initial begin
    rst = 1'b1; run_a = 1'b0; step_a = 1'b0; run_b = 1'b0; step_b = 1'b0;
    repeat (2) @(negedge clk);
    push_const(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1);
    check_now(0, "reset");
    rst = 1'b0;
    push_const(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4);
    push_const(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2);
    tick(0, "init", 6);

    // free run for ten cycles, run dropped on the last GAP2
    run_a = 1'b1;
    for (int k = 0; k < 10; k++) push_cycle(2, 1, k, 16'hFFFF, 6);
    tick(0, "freerun", 60);
    run_a = 1'b0;
    push_const(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 2);
    tick(0, "freerun_idle", 2);

    // single step, with a second pulse during PH2 that must be ignored
    step_a = 1'b1;
    push_cycle(2, 1, 10, 16'hFFFF, 6);
    tick(0, "step", 1);
    step_a = 1'b0;
    tick(0, "step", 3);
    step_a = 1'b1;
    tick(0, "step_in_ph2", 1);
    step_a = 1'b0;
    tick(0, "step", 1);
    push_const(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11, 3);
    tick(0, "step_idle", 3);

    // run dropped in PH1: full cycle still completes
    run_a = 1'b1;
    push_cycle(2, 1, 11, 16'hFFFF, 6);
    tick(0, "rundrop", 1);
    run_a = 1'b0;
    tick(0, "rundrop", 5);
    push_const(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12, 2);
    tick(0, "rundrop_idle", 2);

    // reset in the middle of PH2
    run_a = 1'b1;
    push_cycle(2, 1, 12, 16'hFFFF, 4);
    tick(0, "pre_rst", 4);
    rst = 1'b1;
    run_a = 1'b0;
    push_const(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1);
    tick(0, "rst_mid_ph2", 1);
    rst = 1'b0;
    push_const(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4);
    push_const(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
    tick(0, "reinit", 5);

    // 8-clk period and 4-bit wrap: 17 cycles leave the count at 1
    run_b = 1'b1;
    for (int k = 0; k < 17; k++) push_cycle(1, 3, k & 15, 15, 8);
    tick(1, "wrap_run", 136);
    run_b = 1'b0;
    push_const(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2);
    tick(1, "wrap_idle", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
